// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program loader for the instruction RAM read by the fetch stage.
// It accepts a byte stream with three parts, all big-endian:
//   1. a 32-bit word count N,
//   2. N 32-bit instruction words,
//   3. a 32-bit checksum, which is the sum of the words modulo 2^32.
// Each assembled word goes out through a one-cycle write strobe. The core is
// held in reset (cpuHold) until a load finishes with a matching checksum.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   start            pulse; begins a load from IDLE, DONE or ERROR
//   inValid/inData   byte stream input; a byte moves when inValid && inReady
//   inReady          registered; high in HEADER, DATA and CHECK only
//   memWriteEnable   one-cycle write strobe to the instruction RAM
//   memWriteAddress  word index (0 = first instruction, byte address 0x3000)
//   memWriteData     word to write
//   cpuHold          holds the core's PC and pipeline in reset while 1
//   loadDone         level; the last load finished with a matching checksum
//   loadError        level; the count was too large or the checksum mismatched
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  inValid,
  input  logic [7:0]            inData,
  output logic                  inReady,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memWriteAddress,
  output logic [31:0]           memWriteData,
  output logic                  cpuHold,
  output logic                  loadDone,
  output logic                  loadError
);

  // The word count needs one more bit than an address because N can equal
  // 2^ADDR_WIDTH.
  localparam int                CNT_W        = ADDR_WIDTH + 1;
  localparam logic [31:0]       MAX_WORDS_32 = 32'(MAX_WORDS);
  localparam logic [CNT_W-1:0]  ONE_IDX      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [1:0]       byteCount;   // bytes of the current word already taken
  logic [23:0]      shiftReg;    // first three bytes of the current word
  logic [CNT_W-1:0] wordCount;   // N, kept only after the range check
  logic [CNT_W-1:0] wordIndex;   // next word index to be written
  logic [31:0]      checksum;    // running sum of the written words

  logic             accept;
  logic             lastByte;
  logic [31:0]      fullWord;
  logic [CNT_W-1:0] nextIndex;

  // A word is complete when its fourth byte is accepted. The byte arriving
  // this cycle is the least significant one, so the word is formed
  // combinationally. That lets the write be registered on the same edge
  // without stalling the stream.
  assign accept    = inValid && inReady;
  assign lastByte  = (byteCount == 2'd3);
  assign fullWord  = {shiftReg, inData};
  assign nextIndex = wordIndex + ONE_IDX;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      byteCount       <= 2'd0;
      shiftReg        <= 24'd0;
      wordCount       <= '0;
      wordIndex       <= '0;
      checksum        <= 32'd0;
      inReady         <= 1'b0;
      memWriteEnable  <= 1'b0;
      memWriteAddress <= '0;
      memWriteData    <= 32'd0;
      cpuHold         <= 1'b1;
      loadDone        <= 1'b0;
      loadError       <= 1'b0;
    end else begin
      // The write strobe lasts exactly one cycle unless it is set again below.
      memWriteEnable <= 1'b0;

      case (state)
        // Idle and both terminal states restart the same way. cpuHold rises
        // on the start edge, so a finished core is frozen before the first
        // new word can land in its instruction RAM.
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state     <= S_HEADER;
            inReady   <= 1'b1;
            cpuHold   <= 1'b1;
            loadDone  <= 1'b0;
            loadError <= 1'b0;
            checksum  <= 32'd0;
            byteCount <= 2'd0;
            wordIndex <= '0;
          end
        end

        S_HEADER: begin
          if (accept) begin
            byteCount <= byteCount + 2'd1;
            shiftReg  <= fullWord[23:0];
            if (lastByte) begin
              if (fullWord > MAX_WORDS_32) begin
                state     <= S_ERROR;
                inReady   <= 1'b0;
                loadError <= 1'b1;
              end else if (fullWord == 32'd0) begin
                state <= S_CHECK;
              end else begin
                state     <= S_DATA;
                wordCount <= fullWord[CNT_W-1:0];
                wordIndex <= '0;
              end
            end
          end
        end

        // The write and the checksum update share the completing edge. On
        // the last word the state moves straight to CHECK, so the first
        // checksum byte can follow in the very next cycle.
        S_DATA: begin
          if (accept) begin
            byteCount <= byteCount + 2'd1;
            shiftReg  <= fullWord[23:0];
            if (lastByte) begin
              memWriteEnable  <= 1'b1;
              memWriteAddress <= wordIndex[ADDR_WIDTH-1:0];
              memWriteData    <= fullWord;
              checksum        <= checksum + fullWord;
              wordIndex       <= nextIndex;
              if (nextIndex == wordCount) begin
                state <= S_CHECK;
              end
            end
          end
        end

        S_CHECK: begin
          if (accept) begin
            byteCount <= byteCount + 2'd1;
            shiftReg  <= fullWord[23:0];
            if (lastByte) begin
              inReady <= 1'b0;
              if (fullWord == checksum) begin
                state    <= S_DONE;
                cpuHold  <= 1'b0;
                loadDone <= 1'b1;
              end else begin
                state     <= S_ERROR;
                loadError <= 1'b1;
              end
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          inReady <= 1'b0;
          cpuHold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. The reference model works from the
// load's contents: the list of words, their modulo-2^32 sum and the supplied
// checksum. From these it predicts the write sequence, the write timing
// (measured in accepted bytes) and the final status flags.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_WIDTH = 12;
  localparam int MAX_WORDS  = 4096;

  logic                  clk     = 1'b0;
  logic                  reset   = 1'b0;
  logic                  start   = 1'b0;
  logic                  inValid = 1'b0;
  logic [7:0]            inData  = 8'd0;
  logic                  inReady;
  logic                  memWriteEnable;
  logic [ADDR_WIDTH-1:0] memWriteAddress;
  logic [31:0]           memWriteData;
  logic                  cpuHold;
  logic                  loadDone;
  logic                  loadError;

  imem_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .inValid        (inValid),
    .inData         (inData),
    .inReady        (inReady),
    .memWriteEnable (memWriteEnable),
    .memWriteAddress(memWriteAddress),
    .memWriteData   (memWriteData),
    .cpuHold        (cpuHold),
    .loadDone       (loadDone),
    .loadError      (loadError)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int acc_base = 0;

  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_acc[$];
  logic [31:0] exp_words[$];

  // Count accepted bytes, and record every write together with the number
  // of bytes accepted since the load started.
  always @(posedge clk) begin
    if (inValid && inReady) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (memWriteEnable) begin
      obs_addr.push_back(int'(memWriteAddress));
      obs_data.push_back(memWriteData);
      obs_acc.push_back(acc_cnt - acc_base);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    acc_base = acc_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        inValid = 1'b0;
        inData  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    inValid = 1'b1;
    inData  = b;
    guard   = 0;
    while (!inReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!inReady) begin
      chk("ready_timeout", 32'(inReady), 32'd1);
      inValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    send_byte(w[31:24], gaps);
    send_byte(w[23:16], gaps);
    send_byte(w[15:8],  gaps);
    send_byte(w[7:0],   gaps);
  endtask

  // Word k must go to address k, and its strobe must come right after the
  // load's (8 + 4k)-th accepted byte: 4 header bytes plus k+1 whole words.
  task automatic check_writes(input int n);
    chk("wcount", obs_addr.size(), n);
    for (int k = 0; k < n && k < obs_addr.size(); k++) begin
      chk($sformatf("waddr%0d", k), obs_addr[k], k);
      chk($sformatf("wdata%0d", k), obs_data[k], exp_words[k]);
      chk($sformatf("wlat%0d", k), obs_acc[k], 8 + 4 * k);
    end
  endtask

  task automatic run_load(input int n, input logic [31:0] cs, input bit gaps,
                          input bit need_start, input string tag);
    logic [31:0] sum;
    bit          good;
    obs_addr.delete();
    obs_data.delete();
    obs_acc.delete();
    if (need_start) do_start();
    send_word(32'(n), gaps);
    if (n > MAX_WORDS) begin
      inValid = 1'b0;
      chk({tag, "_ready"}, 32'(inReady),   32'd0);
      chk({tag, "_err"},   32'(loadError), 32'd1);
      chk({tag, "_hold"},  32'(cpuHold),   32'd1);
      chk({tag, "_done"},  32'(loadDone),  32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_nowrite"}, obs_addr.size(), 0);
      return;
    end
    sum = 32'd0;
    foreach (exp_words[k]) begin
      send_word(exp_words[k], gaps);
      sum += exp_words[k];
    end
    send_word(cs, gaps);
    inValid = 1'b0;
    check_writes(n);
    good = (cs == sum);
    chk({tag, "_done"},  32'(loadDone),  32'(good));
    chk({tag, "_err"},   32'(loadError), 32'(!good));
    chk({tag, "_hold"},  32'(cpuHold),   32'(!good));
    chk({tag, "_ready"}, 32'(inReady),   32'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] s;
    logic [31:0] cs;

    // Reset values.
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold",  32'(cpuHold),         32'd1);
    chk("rst_ready", 32'(inReady),         32'd0);
    chk("rst_we",    32'(memWriteEnable),  32'd0);
    chk("rst_addr",  32'(memWriteAddress), 32'd0);
    chk("rst_data",  memWriteData,         32'd0);
    chk("rst_done",  32'(loadDone),        32'd0);
    chk("rst_err",   32'(loadError),       32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", 32'(inReady), 32'd0);

    // Two words with a good checksum, then the same words with a bad one.
    exp_words = '{32'h3C010000, 32'h34210004};
    run_load(2, 32'h70220004, 1'b0, 1'b1, "ok2");
    run_load(2, 32'h70220005, 1'b0, 1'b1, "bad2");

    // Oversized count.
    exp_words.delete();
    run_load(4097, 32'd0, 1'b0, 1'b1, "big");

    // Empty program, then a restart from DONE.
    exp_words.delete();
    run_load(0, 32'd0, 1'b0, 1'b1, "empty");
    do_start();
    chk("restart_hold",  32'(cpuHold),  32'd1);
    chk("restart_done",  32'(loadDone), 32'd0);
    chk("restart_ready", 32'(inReady),  32'd1);

    // Three random words with random inValid gaps; reuses the start above.
    exp_words.delete();
    s = 32'd0;
    for (int k = 0; k < 3; k++) begin
      exp_words.push_back($urandom);
      s += exp_words[k];
    end
    run_load(3, s, 1'b1, 1'b0, "gap3");

    // Random loads with random gaps and sometimes a corrupted checksum.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 7);
      exp_words.delete();
      s = 32'd0;
      for (int k = 0; k < n; k++) begin
        exp_words.push_back($urandom);
        s += exp_words[k];
      end
      cs = ($urandom_range(0, 1) == 1) ? s : (s ^ (32'd1 << $urandom_range(0, 31)));
      run_load(n, cs, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", it));
    end

    // Reset after the second of four data words, with start held high
    // throughout the load.
    exp_words = '{32'hA5A5_0001, 32'h1234_5678};
    obs_addr.delete();
    obs_data.delete();
    obs_acc.delete();
    do_start();
    start = 1'b1;
    send_word(32'd4, 1'b0);
    send_word(exp_words[0], 1'b0);
    send_word(exp_words[1], 1'b0);
    inValid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_hold",  32'(cpuHold),         32'd1);
    chk("mid_ready", 32'(inReady),         32'd0);
    chk("mid_we",    32'(memWriteEnable),  32'd0);
    chk("mid_addr",  32'(memWriteAddress), 32'd0);
    chk("mid_data",  memWriteData,         32'd0);
    chk("mid_done",  32'(loadDone),        32'd0);
    chk("mid_err",   32'(loadError),       32'd0);
    check_writes(2);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_ready", 32'(inReady), 32'd0);
    chk("post_hold",  32'(cpuHold), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that writes the instruction memory the fetch stage reads from. It accepts a byte stream: a 32-bit word count, then the instruction words, then a 32-bit checksum. It writes each assembled word into instruction RAM through a one-cycle write port and holds the core in reset until a load completes with a matching checksum.

Parameters:
ADDR_WIDTH, 12, word-address width of instruction RAM (capacity 2^ADDR_WIDTH words = 4096)
MAX_WORDS, 4096, largest accepted word count; must be <= 2^ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; begins a load from IDLE, DONE or ERROR
inValid  input  1  byte on inData is valid
inData  input  8  stream byte
inReady  output  1  loader can accept a byte this cycle
memWriteEnable  output  1  one-cycle write strobe to instruction RAM
memWriteAddress  output  ADDR_WIDTH  word index, 0 = first instruction (byte address 0x3000)
memWriteData  output  32  word to write
cpuHold  output  1  holds the core (PC/pipeline) in reset while 1
loadDone  output  1  level; load finished, checksum matched
loadError  output  1  level; count too large or checksum mismatch

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is high and until the first start, outputs are: cpuHold=1, inReady=0, memWriteEnable=0, memWriteAddress=0, memWriteData=0, loadDone=0, loadError=0. All counters are 0 and the state is IDLE.
- Handshake: a byte is accepted on a rising edge where inValid && inReady.
  - inReady is a registered function of state: 1 in HEADER, DATA and CHECK; 0 elsewhere.
  - inData is ignored when inValid=0.
- Word assembly: bytes are big-endian; the first byte goes to [31:24]. A 2-bit byte counter wraps 3->0 when a word completes.
- States:
  - IDLE: cpuHold=1. start -> HEADER; also clears loadDone and loadError.
  - HEADER: collects 4 bytes into count N.
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> CHECK.
    - Otherwise -> DATA, with word index 0.
  - DATA: on each completed word, the next cycle drives memWriteEnable=1 for exactly one cycle, with memWriteAddress=index and memWriteData=word.
    - The index increments after the write and the word is added into the checksum (modulo 2^32).
    - When index reaches N -> CHECK.
  - CHECK: collects a 4-byte checksum.
    - Equal to the accumulated sum (0 when N=0) -> DONE.
    - Otherwise -> ERROR.
  - DONE: cpuHold=0, loadDone=1, inReady=0. start -> HEADER, which sets cpuHold=1 in the same edge.
  - ERROR: cpuHold=1, loadError=1, inReady=0. start -> HEADER.
- start in HEADER, DATA or CHECK is ignored.
- Write latency: memWriteEnable rises on the edge after the 4th byte of a word is accepted. Back-to-back bytes every cycle must be sustained without loss, so the write register never stalls inReady.
- Index 4095 is the last writable word; index never wraps because N <= MAX_WORDS.
- The checksum is cleared on entry to HEADER.
- Reset mid-load: immediately returns to IDLE with reset values. Words already written stay in RAM; no partial status is retained.

Test Plan:
- Reset then start, stream N=2, words 0x3C010000 and 0x34210004, checksum 0x70220004 -> two write pulses: addr0 = 0x3C010000, addr1 = 0x34210004. DONE, cpuHold=0, loadDone=1.
- Same stream with checksum 0x70220005 -> both words written, then ERROR: loadError=1, cpuHold=1, loadDone=0.
- Header N=4097 -> ERROR right after the 4th header byte; no memWriteEnable pulses; inReady drops to 0.
- N=0 with checksum 0 -> DONE with no writes. A later start -> cpuHold=1 and loadDone=0 on the same edge.
- inValid toggled randomly with one byte per accepted cycle, N=3 -> writes exactly match the words, in order, at addresses 0..2.
- reset asserted after the 2nd data word -> outputs go to reset values asynchronously; state IDLE; start during the load is ignored up to that point.
